// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the RV32I memory stage: ResultSrc
//               selects, load/store funct3 codes, FSM state codes and the
//               alignment check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Write-back source select (ResultSrcM). 2'b11 falls back to the ALU path.
  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  // Access size / sign codes (funct3M).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory-access FSM states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // size = funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 included).
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == 2'b01) begin
      mis = addr_lo[0];
    end else if (size[1]) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data aligner. Picks the addressed byte or
//               halfword out of the read word and sign/zero-extends it; word
//               accesses pass the full word through.
// Revision    : 1.0 - initial release
// Ports       : funct3   in  3   access size/sign
//               addr_lo  in  2   byte offset within the word
//               rdata    in  32  raw read word
//               ld_data  out 32  extended load value
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'h000000, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'h0000, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32I MEM stage. Drives a req/ready data-memory bus with
//               byte enables, aligns load data, flags misaligned accesses and
//               bus timeouts, and holds the MEM/WB write-back register.
// Revision    : 1.0 - initial release
// Ports       : clk, rst (sync, active-low)
//               EX/MEM in : ALUResultM, WriteDataM, ImmExtM, PCPlus4M, RdM,
//                           funct3M, RegWriteM, MemWriteM, loadimm_selM,
//                           ResultSrcM
//               bus        : dmem_req/we/addr/wdata/be out, dmem_ready/rdata in
//               status out : stallM, misalignM, bus_errM
//               MEM/WB out : RegWriteW, RdW, ResultW
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ImmExtM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic [2:0]  funct3M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        loadimm_selM,
  input  logic [1:0]  ResultSrcM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic        misalignM,
  output logic        bus_errM,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reg_write_w_q, reg_write_w_d;
  logic [4:0]       rd_w_q, rd_w_d;
  logic [31:0]      result_w_q, result_w_d;

  logic        access;
  logic        misaligned;
  logic        req;
  logic        stall;
  logic        mis_pulse;
  logic        berr_pulse;
  logic [31:0] ld_data;
  logic [31:0] alu_val;

  load_align u_load_align (
    .funct3  (funct3M),
    .addr_lo (ALUResultM[1:0]),
    .rdata   (dmem_rdata),
    .ld_data (ld_data)
  );

  assign access     = MemWriteM | (ResultSrcM == RS_LOAD);
  assign misaligned = is_misaligned(funct3M[1:0], ALUResultM[1:0]);
  assign alu_val    = loadimm_selM ? ImmExtM : ALUResultM;

  // Access FSM. The IDLE cycle already issues the request so a zero-wait
  // slave completes without any stall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req        = 1'b0;
    stall      = 1'b0;
    mis_pulse  = 1'b0;
    berr_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (misaligned) begin
            mis_pulse = 1'b1;
          end else begin
            req = 1'b1;
            if (!dmem_ready) begin
              stall   = 1'b1;
              state_d = ST_BUSY;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_BUSY: begin
        req = 1'b1;
        if (dmem_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          berr_pulse = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          stall = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Reset also silences the bus and status outputs in the same cycle.
    if (!rst) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      req        = 1'b0;
      stall      = 1'b0;
      mis_pulse  = 1'b0;
      berr_pulse = 1'b0;
    end
  end

  // MEM/WB register: a stall inserts a bubble and holds the data fields.
  always_comb begin
    reg_write_w_d = reg_write_w_q;
    rd_w_d        = rd_w_q;
    result_w_d    = result_w_q;
    if (!rst) begin
      reg_write_w_d = 1'b0;
      rd_w_d        = '0;
      result_w_d    = '0;
    end else if (stall) begin
      reg_write_w_d = 1'b0;
    end else begin
      reg_write_w_d = RegWriteM & ~mis_pulse & ~berr_pulse;
      rd_w_d        = RdM;
      case (ResultSrcM)
        RS_LOAD: result_w_d = ld_data;
        RS_PC4:  result_w_d = PCPlus4M;
        default: result_w_d = alu_val;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    cnt_q         <= cnt_d;
    reg_write_w_q <= reg_write_w_d;
    rd_w_q        <= rd_w_d;
    result_w_q    <= result_w_d;
  end

  // Store lane steering; loads always read the whole word.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << ALUResultM[1:0];
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM;
        end
      endcase
    end
  end

  assign dmem_req  = req;
  assign dmem_we   = req & MemWriteM;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};
  assign stallM    = stall;
  assign misalignM = mis_pulse;
  assign bus_errM  = berr_pulse;
  assign RegWriteW = reg_write_w_q;
  assign RdW       = rd_w_q;
  assign ResultW   = result_w_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed scenarios with
//               literal expectations plus randomized instruction streams
//               checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, ImmExtM, PCPlus4M;
  logic [4:0]  RdM;
  logic [2:0]  funct3M;
  logic        RegWriteM, MemWriteM, loadimm_selM;
  logic [1:0]  ResultSrcM;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stallM, misalignM, bus_errM;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ImmExtM(ImmExtM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .funct3M(funct3M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .loadimm_selM(loadimm_selM), .ResultSrcM(ResultSrcM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stallM(stallM), .misalignM(misalignM),
    .bus_errM(bus_errM), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: cycles the current access has already waited, plus the
  // expected MEM/WB contents.
  int          m_wait = 0;
  logic        m_stall = 1'b0;
  logic        m_regw = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_res = '0;

  // Last observed combinational outputs, for the directed literal checks.
  logic obs_req, obs_we, obs_stall, obs_mis, obs_berr;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    if (f3[1]) return rd;
    if (f3[0] == 1'b0) begin
      v = (rd >> (int'(a) * 8)) & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One clock cycle: check combinational outputs against the model, clock,
  // then check the write-back register.
  task automatic step();
    logic acc, mis, e_req, e_stall, e_mis, e_berr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [1:0]  a;
    logic [1:0]  sz;
    #1;
    a   = ALUResultM[1:0];
    sz  = funct3M[1:0];
    acc = MemWriteM || (ResultSrcM == 2'b01);
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
    e_req = 0; e_stall = 0; e_mis = 0; e_berr = 0;
    if (rst && acc) begin
      if (mis) e_mis = 1;
      else begin
        e_req = 1;
        if (!dmem_ready) begin
          if (m_wait == TIMEOUT) e_berr = 1;
          else e_stall = 1;
        end
      end
    end
    obs_req = dmem_req; obs_we = dmem_we; obs_stall = stallM; obs_mis = misalignM;
    obs_berr = bus_errM; obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_be = dmem_be;
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("stallM", 32'(stallM), 32'(e_stall));
    chk("misalignM", 32'(misalignM), 32'(e_mis));
    chk("bus_errM", 32'(bus_errM), 32'(e_berr));
    if (e_req) begin
      e_be = 4'b1111;
      e_wd = WriteDataM;
      if (MemWriteM && sz == 2'b00) begin
        e_be = 4'b0001 << a;
        e_wd = (WriteDataM & 32'hFF) * 32'h0101_0101;
      end else if (MemWriteM && sz == 2'b01) begin
        e_be = 4'b0011 << (2 * int'(a[1]));
        e_wd = (WriteDataM & 32'hFFFF) * 32'h0001_0001;
      end
      chk("dmem_we", 32'(dmem_we), 32'(MemWriteM));
      chk("dmem_addr", dmem_addr, ALUResultM & 32'hFFFF_FFFC);
      chk("dmem_be", 32'(dmem_be), 32'(e_be));
      chk("dmem_wdata", dmem_wdata, e_wd);
    end
    m_stall = e_stall;
    @(posedge clk);
    if (!rst) begin
      m_regw = 0; m_rd = 0; m_res = 0;
    end else if (e_stall) begin
      m_regw = 0;
    end else begin
      m_regw = RegWriteM && !e_mis && !e_berr;
      m_rd   = RdM;
      if (ResultSrcM == 2'b01)      m_res = model_load(funct3M, a, dmem_rdata);
      else if (ResultSrcM == 2'b10) m_res = PCPlus4M;
      else                          m_res = loadimm_selM ? ImmExtM : ALUResultM;
    end
    m_wait = (rst && e_stall) ? m_wait + 1 : 0;
    #1;
    chk("RegWriteW", 32'(RegWriteW), 32'(m_regw));
    chk("RdW", 32'(RdW), 32'(m_rd));
    chk("ResultW", ResultW, m_res);
  endtask

  task automatic set_instr(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] rs,
                           input logic mw, input logic rw, input logic [4:0] rd);
    funct3M = f3; ALUResultM = addr; WriteDataM = wd; ResultSrcM = rs;
    MemWriteM = mw; RegWriteM = rw; RdM = rd;
    ImmExtM = 32'h1234_5000; PCPlus4M = 32'h0000_0404; loadimm_selM = 1'b0;
  endtask

  task automatic set_nop();
    set_instr(3'b000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 5'd0);
    ImmExtM = 32'h0;
  endtask

  initial begin
    int n_stall;
    int mode;
    int guard;
    rst = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    set_nop();
    step(); step();
    chk("reset_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset_ResultW", ResultW, 32'h0);
    rst = 1'b1;

    // 1: zero-wait lw
    set_instr(3'b010, 32'h100, 32'h0, 2'b01, 1'b0, 1'b1, 5'd5);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    chk("t1_stall", 32'(obs_stall), 32'd0);
    chk("t1_RegWriteW", 32'(RegWriteW), 32'd1);
    chk("t1_RdW", 32'(RdW), 32'd5);
    chk("t1_ResultW", ResultW, 32'hDEADBEEF);

    // 2: lb with three wait cycles, then lbu
    set_instr(3'b000, 32'h103, 32'h0, 2'b01, 1'b0, 1'b1, 5'd7);
    dmem_rdata = 32'h80112233;
    for (int i = 0; i < 3; i++) begin
      dmem_ready = 1'b0;
      step();
      chk("t2_stall", 32'(obs_stall), 32'd1);
      chk("t2_bubble", 32'(RegWriteW), 32'd0);
    end
    dmem_ready = 1'b1;
    step();
    chk("t2_stall_end", 32'(obs_stall), 32'd0);
    chk("t2_lb", ResultW, 32'hFFFFFF80);
    funct3M = 3'b100;
    step();
    chk("t2_lbu", ResultW, 32'h00000080);

    // 3: sh to 0x202
    set_instr(3'b001, 32'h202, 32'h0000ABCD, 2'b00, 1'b1, 1'b0, 5'd0);
    dmem_ready = 1'b1;
    step();
    chk("t3_we", 32'(obs_we), 32'd1);
    chk("t3_addr", obs_addr, 32'h200);
    chk("t3_be", 32'(obs_be), 32'hC);
    chk("t3_wdata", obs_wdata, 32'hABCDABCD);
    chk("t3_RegWriteW", 32'(RegWriteW), 32'd0);

    // 4: misaligned lw and sh
    set_instr(3'b010, 32'h101, 32'h0, 2'b01, 1'b0, 1'b1, 5'd9);
    step();
    chk("t4_lw_req", 32'(obs_req), 32'd0);
    chk("t4_lw_mis", 32'(obs_mis), 32'd1);
    chk("t4_lw_regw", 32'(RegWriteW), 32'd0);
    set_nop();
    step();
    chk("t4_mis_pulse_end", 32'(obs_mis), 32'd0);
    set_instr(3'b001, 32'h203, 32'h5555, 2'b00, 1'b1, 1'b0, 5'd0);
    step();
    chk("t4_sh_req", 32'(obs_req), 32'd0);
    chk("t4_sh_mis", 32'(obs_mis), 32'd1);

    // 5: timeout
    set_instr(3'b010, 32'h300, 32'h0, 2'b01, 1'b0, 1'b1, 5'd3);
    dmem_ready = 1'b0;
    n_stall = 0;
    guard = 0;
    do begin
      step();
      if (obs_stall) n_stall++;
      guard++;
    end while (obs_stall && guard < 40);
    chk("t5_stall_cycles", 32'(n_stall), 32'd16);
    chk("t5_bus_err", 32'(obs_berr), 32'd1);
    chk("t5_RegWriteW", 32'(RegWriteW), 32'd0);
    set_nop();
    step();
    chk("t5_idle_req", 32'(obs_req), 32'd0);

    // 6: reset during the second BUSY cycle
    set_instr(3'b010, 32'h400, 32'h0, 2'b01, 1'b0, 1'b1, 5'd4);
    dmem_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("t6_stall", 32'(obs_stall), 32'd0);
    chk("t6_req", 32'(obs_req), 32'd0);
    chk("t6_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("t6_ResultW", ResultW, 32'h0);
    rst = 1'b1;
    set_nop();
    dmem_ready = 1'b1;
    step();
    chk("t6_late_ready_req", 32'(obs_req), 32'd0);
    chk("t6_late_ready_regw", 32'(RegWriteW), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 600; n++) begin
      set_instr(3'($urandom), $urandom, $urandom, 2'($urandom),
                ($urandom_range(0, 9) < 3), 1'($urandom), 5'($urandom));
      if ($urandom_range(0, 1) == 0) ALUResultM[1:0] = 2'b00;
      ImmExtM = $urandom; PCPlus4M = $urandom; loadimm_selM = 1'($urandom);
      mode = $urandom_range(0, 19);
      guard = 0;
      do begin
        if (mode == 0)      dmem_ready = 1'b0;
        else if (mode < 7)  dmem_ready = 1'b1;
        else                dmem_ready = ($urandom_range(0, 9) < 4);
        dmem_rdata = $urandom;
        rst = ($urandom_range(0, 199) != 0);
        step();
        guard++;
      end while (m_stall && guard < 40);
      chk("rand_access_bounded", 32'(m_stall), 32'd0);
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
